// File: rtl/score_ssd_driver.sv
// Eight-digit multiplexed seven-segment driver for the score/lives display.
// Inputs are snapshotted once per scan frame so every frame is self-consistent.
module score_ssd_driver #(
   parameter int SCAN_BITS  = 18,
   parameter int BLINK_BITS = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] score_ones,
   input  logic [3:0] score_tens,
   input  logic [3:0] lives,
   input  logic       game_over,
   output logic [7:0] an,
   output logic [6:0] ssd,
   output logic       dp
);

   logic [SCAN_BITS-1:0]  scan_cnt_reg;
   logic [BLINK_BITS-1:0] blink_cnt_reg;
   logic [3:0]            ones_reg;
   logic [3:0]            tens_reg;
   logic [3:0]            lives_reg;
   logic                  game_over_reg;

   logic [2:0] idx;
   logic       frame_wrap;
   logic       blink_off;

   logic [7:0] an_next;
   logic [6:0] ssd_next;
   logic       dp_next;
   logic [3:0] digit_val;
   logic       digit_on;

   assign idx        = scan_cnt_reg[SCAN_BITS-1 -: 3];
   assign frame_wrap = &scan_cnt_reg;
   assign blink_off  = game_over_reg & blink_cnt_reg[BLINK_BITS-1];

   function automatic logic [6:0] seg_encode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_reg  <= '0;
         blink_cnt_reg <= '0;
      end else begin
         scan_cnt_reg  <= scan_cnt_reg + 1'b1;
         blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
   end

   // Snapshot only on the edge that wraps the scan counter back to digit 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_reg      <= 4'd0;
         tens_reg      <= 4'd0;
         lives_reg     <= 4'd0;
         game_over_reg <= 1'b0;
      end else if (frame_wrap) begin
         ones_reg      <= score_ones;
         tens_reg      <= score_tens;
         lives_reg     <= lives;
         game_over_reg <= game_over;
      end
   end

   always_comb begin
      digit_on  = 1'b0;
      digit_val = 4'd0;
      an_next   = 8'hFF;
      ssd_next  = 7'h7F;
      dp_next   = 1'b1;
      case (idx)
         3'd0: begin
            digit_on  = 1'b1;
            digit_val = ones_reg;
         end
         3'd1: begin
            digit_on  = (tens_reg != 4'd0);
            digit_val = tens_reg;
         end
         3'd4: begin
            digit_on  = 1'b1;
            digit_val = lives_reg;
         end
         default: digit_on = 1'b0;
      endcase
      if (blink_off)
         digit_on = 1'b0;
      if (digit_on) begin
         an_next  = ~(8'd1 << idx);
         ssd_next = seg_encode(digit_val);
         dp_next  = (idx != 3'd4);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 8'hFF;
         ssd <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         ssd <= ssd_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_score_ssd_driver.sv
// Randomized self-checking bench for score_ssd_driver (6-bit scan, 8-bit blink).
// The reference tracks elapsed cycles since reset and derives digit/blink from them.
module tb_score_ssd_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] score_ones = 4'd0;
   logic [3:0] score_tens = 4'd0;
   logic [3:0] lives = 4'd0;
   logic       game_over = 1'b0;
   logic [7:0] an;
   logic [6:0] ssd;
   logic       dp;

   int n_checks = 0;
   int n_fail = 0;

   // reference state
   int         m_t;
   logic [3:0] m_ones, m_tens, m_lives;
   logic       m_go;
   logic [7:0] e_an;
   logic [6:0] e_ssd;
   logic       e_dp;
   int         e_idx;
   bit         e_blink;

   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   score_ssd_driver #(.SCAN_BITS(6), .BLINK_BITS(8)) dut (
      .clk(clk), .rst(rst), .score_ones(score_ones), .score_tens(score_tens),
      .lives(lives), .game_over(game_over), .an(an), .ssd(ssd), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_t = 0;
      m_ones = 0;
      m_tens = 0;
      m_lives = 0;
      m_go = 0;
   endtask

   // One clock edge: predict outputs from the pre-edge reference state, then advance it
   task automatic step();
      bit on;
      logic [3:0] v;
      @(posedge clk);
      e_idx   = (m_t % 64) / 8;
      e_blink = (m_t % 256) >= 128;
      on = 0;
      v  = 0;
      if (e_idx == 0) begin on = 1; v = m_ones; end
      else if (e_idx == 1) begin on = (m_tens != 0); v = m_tens; end
      else if (e_idx == 4) begin on = 1; v = m_lives; end
      if (m_go && e_blink) on = 0;
      e_an  = on ? (8'hFF ^ (8'd1 << e_idx)) : 8'hFF;
      e_ssd = on ? ((v > 9) ? 7'b0111111 : seg_tab[v]) : 7'h7F;
      e_dp  = !(on && e_idx == 4);
      if (m_t % 64 == 63) begin
         m_ones = score_ones;
         m_tens = score_tens;
         m_lives = lives;
         m_go = game_over;
      end
      m_t++;
      #1;
   endtask

   task automatic test_reset();
      score_ones = 4'd1 + 4'($urandom_range(0, 8));
      score_tens = 4'd1 + 4'($urandom_range(0, 8));
      lives = 4'($urandom_range(1, 9));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({an, ssd, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: an=%h ssd=%b dp=%b, want an=ff ssd=1111111 dp=1", an, ssd, dp);
         end
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 64; i++) begin
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL reset_first_frame t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
         if (e_idx == 0) begin
            n_checks++;
            if (ssd !== 7'b1000000 || an !== 8'hFE) begin
               n_fail++;
               $display("FAIL reset_digit0: an=%h ssd=%b, want an=fe ssd=1000000", an, ssd);
            end
         end else if (e_idx == 1) begin
            n_checks++;
            if (an !== 8'hFF) begin
               n_fail++;
               $display("FAIL reset_digit1_blank: an=%h, want ff", an);
            end
         end
      end
   endtask

   task automatic test_digits();
      int n;
      score_ones = 4'd7;
      score_tens = 4'd4;
      lives = 4'd3;
      game_over = 1'b0;
      n = 64 - (m_t % 64);
      for (int i = 0; i < n + 64; i++) begin
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL digits t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
         if (i >= n) begin
            n_checks++;
            if ((e_idx == 0 && {an, ssd, dp} !== {8'hFE, 7'b1111000, 1'b1}) ||
                (e_idx == 1 && {an, ssd, dp} !== {8'hFD, 7'b0011001, 1'b1}) ||
                (e_idx == 4 && {an, ssd, dp} !== {8'hEF, 7'b0110000, 1'b0}) ||
                (e_idx == 2 && {an, dp} !== {8'hFF, 1'b1})) begin
               n_fail++;
               $display("FAIL digits_fixed idx=%0d: an=%h ssd=%b dp=%b", e_idx, an, ssd, dp);
            end
         end
      end
   endtask

   task automatic test_capture();
      int n;
      for (int i = 0; i < 4; i++) step();
      score_ones = 4'd2;
      n = 64 - (m_t % 64);
      for (int i = 0; i < n + 16; i++) begin
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL capture t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
         if (e_idx == 0) begin
            n_checks++;
            if (ssd !== ((i < n) ? 7'b1111000 : 7'b0100100)) begin
               n_fail++;
               $display("FAIL capture_ones i=%0d: ssd=%b, want %b", i, ssd,
                        (i < n) ? 7'b1111000 : 7'b0100100);
            end
         end
      end
   endtask

   task automatic test_blank_tens();
      int n;
      score_ones = 4'd5;
      score_tens = 4'd0;
      n = 64 - (m_t % 64);
      for (int i = 0; i < n + 64; i++) begin
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL tens_zero t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
         if (i >= n && an === 8'hFD) begin
            n_fail++;
            $display("FAIL tens_zero_active: an=%h, want digit 1 never active", an);
         end
      end
      score_tens = 4'd12;
      n = 64 - (m_t % 64);
      for (int i = 0; i < n + 64; i++) begin
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL tens_dash t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
         if (i >= n && e_idx == 1) begin
            n_checks++;
            if ({an, ssd} !== {8'hFD, 7'b0111111}) begin
               n_fail++;
               $display("FAIL tens_dash_fixed: an=%h ssd=%b, want an=fd ssd=0111111", an, ssd);
            end
         end
      end
   endtask

   task automatic test_game_over();
      int n;
      game_over = 1'b1;
      lives = 4'd0;
      n = 64 - (m_t % 64);
      for (int i = 0; i < n + 512; i++) begin
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL game_over t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
         if (i >= n && (e_blink || e_idx == 4)) begin
            n_checks++;
            if (e_blink ? ({an, dp} !== {8'hFF, 1'b1})
                        : ({an, ssd, dp} !== {8'hEF, 7'b1000000, 1'b0})) begin
               n_fail++;
               $display("FAIL game_over_fixed blink=%0d idx=%0d: an=%h ssd=%b dp=%b",
                        e_blink, e_idx, an, ssd, dp);
            end
         end
      end
      game_over = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            score_ones = 4'($urandom);
            score_tens = 4'($urandom);
            lives = 4'($urandom);
            game_over = 1'($urandom);
         end
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL random t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
      end
   endtask

   task automatic test_reset_mid();
      game_over = 1'b0;
      score_ones = 4'd9;
      score_tens = 4'd3;
      lives = 4'd6;
      for (int i = 0; i < 64 && (m_t % 64) != 42; i++) step();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({an, ssd, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_async: an=%h ssd=%b dp=%b, want an=ff ssd=1111111 dp=1", an, ssd, dp);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if ({an, ssd, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_hold: an=%h ssd=%b dp=%b, want an=ff ssd=1111111 dp=1", an, ssd, dp);
      end
      rst = 1'b0;
      model_reset();
      step();
      n_checks++;
      if ({an, ssd, dp} !== {8'hFE, 7'b1000000, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_restart: an=%h ssd=%b dp=%b, want an=fe ssd=1000000 dp=1", an, ssd, dp);
      end
      for (int i = 0; i < 130; i++) begin
         step();
         n_checks++;
         if ({an, ssd, dp} !== {e_an, e_ssd, e_dp}) begin
            n_fail++;
            $display("FAIL reset_mid_after t=%0d: an=%h ssd=%b dp=%b, want an=%h ssd=%b dp=%b",
                     m_t, an, ssd, dp, e_an, e_ssd, e_dp);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_digits();
      test_capture();
      test_blank_tens();
      test_game_over();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
